// File: rtl/io_bus_arbiter.sv
// Round-robin arbiter letting several cores share one external IO bus,
// with at most one bus transaction outstanding at any time.
package io_bus_arbiter_pkg;
   localparam int THREAD_IDX_W = 2;

   typedef logic [THREAD_IDX_W-1:0] thread_idx_t;
   typedef logic [3:0] core_id_t;

   typedef struct packed {
      logic        valid;
      logic        is_store;
      logic [31:0] address;
      logic [31:0] value;
      thread_idx_t thread_idx;
   } ioreq_packet_t;

   typedef struct packed {
      logic        valid;
      core_id_t    core;
      thread_idx_t thread_idx;
      logic [31:0] read_value;
   } iorsp_packet_t;
endpackage

module io_bus_arbiter
   import io_bus_arbiter_pkg::*;
#(
   parameter int NUM_CORES = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  ioreq_packet_t        core_io_request [NUM_CORES],
   output logic [NUM_CORES-1:0] ia_ready,
   output iorsp_packet_t        ia_response,
   output logic                 io_req_valid,
   output logic                 io_write_en,
   output logic [31:0]          io_address,
   output logic [31:0]          io_write_data,
   input  logic                 io_req_ready,
   input  logic                 io_rsp_valid,
   input  logic [31:0]          io_read_data
);

   typedef enum logic [1:0] {IDLE, REQUEST, WAIT} state_t;

   state_t        state_q, state_d;
   core_id_t      lastGranted_q;
   core_id_t      grantIdx;
   logic          grantFound;
   logic          grantFire;
   logic          isStore_q;
   logic [31:0]   address_q;
   logic [31:0]   value_q;
   thread_idx_t   thread_q;
   core_id_t      core_q;
   iorsp_packet_t rsp_q, rsp_d;

   // Two passes give rotating priority: cores above the last winner first, then wrap to core 0.
   always_comb begin
      grantFound = 1'b0;
      grantIdx   = '0;
      for (int c = 0; c < NUM_CORES; c++) begin
         if (!grantFound && core_io_request[c].valid && c > int'(lastGranted_q)) begin
            grantFound = 1'b1;
            grantIdx   = core_id_t'(c);
         end
      end
      for (int c = 0; c < NUM_CORES; c++) begin
         if (!grantFound && core_io_request[c].valid && c <= int'(lastGranted_q)) begin
            grantFound = 1'b1;
            grantIdx   = core_id_t'(c);
         end
      end
      grantFire = (state_q == IDLE) && grantFound && !reset;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (grantFire)    state_d = REQUEST;
         REQUEST: if (io_req_ready) state_d = WAIT;
         WAIT:    if (io_rsp_valid) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // The completion is turned into a one-cycle response; stores answer with zero data.
   always_comb begin
      rsp_d = '0;
      if (state_q == WAIT && io_rsp_valid) begin
         rsp_d.valid      = 1'b1;
         rsp_d.core       = core_q;
         rsp_d.thread_idx = thread_q;
         rsp_d.read_value = isStore_q ? 32'h0 : io_read_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lastGranted_q <= core_id_t'(NUM_CORES - 1);
         isStore_q     <= 1'b0;
         address_q     <= '0;
         value_q       <= '0;
         thread_q      <= '0;
         core_q        <= '0;
         rsp_q         <= '0;
      end else begin
         rsp_q <= rsp_d;
         if (grantFire) begin
            lastGranted_q <= grantIdx;
            isStore_q     <= core_io_request[grantIdx].is_store;
            address_q     <= core_io_request[grantIdx].address;
            value_q       <= core_io_request[grantIdx].value;
            thread_q      <= core_io_request[grantIdx].thread_idx;
            core_q        <= grantIdx;
         end
      end
   end

   always_comb begin
      ia_ready = '0;
      for (int c = 0; c < NUM_CORES; c++) begin
         ia_ready[c] = grantFire && (grantIdx == core_id_t'(c));
      end
      io_req_valid  = (state_q == REQUEST);
      io_write_en   = (state_q == REQUEST) && isStore_q;
      io_address    = (state_q == REQUEST) ? address_q : 32'h0;
      io_write_data = (state_q == REQUEST) ? value_q : 32'h0;
      ia_response   = rsp_q;
   end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Self-checking bench for io_bus_arbiter: directed scenarios plus a randomized
// run checked against a transaction-level model of the arbitration rules.
module tb_io_bus_arbiter;
   import io_bus_arbiter_pkg::*;

   localparam int N = 4;

   logic          clk = 1'b0;
   logic          reset;
   ioreq_packet_t req [N];
   logic [N-1:0]  ia_ready;
   iorsp_packet_t ia_response;
   logic          io_req_valid;
   logic          io_write_en;
   logic [31:0]   io_address;
   logic [31:0]   io_write_data;
   logic          io_req_ready;
   logic          io_rsp_valid;
   logic [31:0]   io_read_data;

   int nCompared   = 0;
   int nMismatched = 0;

   io_bus_arbiter #(.NUM_CORES(N)) dut (
      .clk            (clk),
      .reset          (reset),
      .core_io_request(req),
      .ia_ready       (ia_ready),
      .ia_response    (ia_response),
      .io_req_valid   (io_req_valid),
      .io_write_en    (io_write_en),
      .io_address     (io_address),
      .io_write_data  (io_write_data),
      .io_req_ready   (io_req_ready),
      .io_rsp_valid   (io_rsp_valid),
      .io_read_data   (io_read_data)
   );

   always #5 clk = ~clk;

   task automatic clearInputs();
      for (int i = 0; i < N; i++) req[i] = '0;
      io_req_ready = 1'b0;
      io_rsp_valid = 1'b0;
      io_read_data = '0;
   endtask

   task automatic applyReset();
      reset = 1'b1;
      clearInputs();
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   function automatic ioreq_packet_t mkReq(logic st, logic [31:0] a, logic [31:0] v, thread_idx_t t);
      ioreq_packet_t p;
      p.valid      = 1'b1;
      p.is_store   = st;
      p.address    = a;
      p.value      = v;
      p.thread_idx = t;
      return p;
   endfunction

   task automatic test_reset();
      reset = 1'b1;
      clearInputs();
      for (int i = 0; i < N; i++) req[i] = mkReq(1'b0, 32'h100 + i, 32'h0, 2'd0);
      @(negedge clk);
      nCompared++;
      if (ia_ready !== '0) begin
         nMismatched++;
         $display("[TB] FAIL reset_ia_ready: got %b want 0", ia_ready);
      end
      nCompared++;
      if ({io_req_valid, io_write_en, io_address, io_write_data} !== 66'h0) begin
         nMismatched++;
         $display("[TB] FAIL reset_bus: got %b %b %h %h want zeros", io_req_valid, io_write_en, io_address, io_write_data);
      end
      nCompared++;
      if (ia_response !== '0) begin
         nMismatched++;
         $display("[TB] FAIL reset_rsp: got %h want 0", ia_response);
      end
      applyReset();
   endtask

   task automatic test_single_load();
      iorsp_packet_t exp;
      applyReset();
      req[2] = mkReq(1'b0, 32'hFFFF0004, 32'h0, 2'd1);
      @(negedge clk);
      nCompared++;
      if (ia_ready !== 4'b0100) begin
         nMismatched++;
         $display("[TB] FAIL single_grant: got %b want 0100", ia_ready);
      end
      nextCycle();
      req[2].valid = 1'b0;
      io_req_ready = 1'b1;
      @(negedge clk);
      nCompared++;
      if ({io_req_valid, io_write_en, io_address} !== {1'b1, 1'b0, 32'hFFFF0004}) begin
         nMismatched++;
         $display("[TB] FAIL single_cmd: got %b %b %h want 1 0 ffff0004", io_req_valid, io_write_en, io_address);
      end
      nextCycle();
      io_req_ready = 1'b0;
      io_rsp_valid = 1'b1;
      io_read_data = 32'h12345678;
      @(negedge clk);
      nCompared++;
      if ({io_req_valid, ia_response.valid} !== 2'b00) begin
         nMismatched++;
         $display("[TB] FAIL single_wait: got req %b rsp %b want 0 0", io_req_valid, ia_response.valid);
      end
      nextCycle();
      io_rsp_valid = 1'b0;
      io_read_data = '0;
      @(negedge clk);
      exp = '{valid: 1'b1, core: 4'd2, thread_idx: 2'd1, read_value: 32'h12345678};
      nCompared++;
      if (ia_response !== exp) begin
         nMismatched++;
         $display("[TB] FAIL single_rsp: got %h want %h", ia_response, exp);
      end
      nextCycle();
      @(negedge clk);
      nCompared++;
      if (ia_response.valid !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL single_rsp_once: got %b want 0", ia_response.valid);
      end
   endtask

   task automatic test_round_robin();
      int grants[$];
      int expOrder[6] = '{0, 1, 3, 0, 1, 3};
      applyReset();
      req[0] = mkReq(1'b0, 32'h1000, 32'h0, 2'd0);
      req[1] = mkReq(1'b0, 32'h1100, 32'h0, 2'd1);
      req[3] = mkReq(1'b0, 32'h1300, 32'h0, 2'd3);
      io_req_ready = 1'b1;
      io_rsp_valid = 1'b1;
      io_read_data = 32'hC0FFEE00;
      for (int cyc = 0; cyc < 18; cyc++) begin
         @(negedge clk);
         if (ia_ready !== '0) begin
            nCompared++;
            if ($countones(ia_ready) != 1) begin
               nMismatched++;
               $display("[TB] FAIL rr_onehot: got %b want one-hot", ia_ready);
            end
            for (int c = 0; c < N; c++) if (ia_ready[c]) grants.push_back(c);
         end
         nextCycle();
      end
      nCompared++;
      if (grants.size() != 6) begin
         nMismatched++;
         $display("[TB] FAIL rr_count: got %0d want 6", grants.size());
      end
      for (int i = 0; i < 6 && i < grants.size(); i++) begin
         nCompared++;
         if (grants[i] != expOrder[i]) begin
            nMismatched++;
            $display("[TB] FAIL rr_grant[%0d]: got %0d want %0d", i, grants[i], expOrder[i]);
         end
      end
      clearInputs();
   endtask

   task automatic test_backpressure();
      iorsp_packet_t exp;
      applyReset();
      req[0] = mkReq(1'b1, 32'hFFFF0010, 32'h000000A5, 2'd2);
      @(negedge clk);
      nCompared++;
      if (ia_ready !== 4'b0001) begin
         nMismatched++;
         $display("[TB] FAIL bp_grant: got %b want 0001", ia_ready);
      end
      nextCycle();
      req[0].valid = 1'b0;
      for (int k = 0; k < 6; k++) begin
         io_req_ready = (k == 5);
         @(negedge clk);
         nCompared++;
         if ({io_req_valid, io_write_en, io_address, io_write_data} !== {1'b1, 1'b1, 32'hFFFF0010, 32'h000000A5}) begin
            nMismatched++;
            $display("[TB] FAIL bp_hold[%0d]: got %b %b %h %h want 1 1 ffff0010 000000a5", k, io_req_valid, io_write_en, io_address, io_write_data);
         end
         nextCycle();
      end
      io_req_ready = 1'b0;
      io_rsp_valid = 1'b1;
      io_read_data = 32'hDEADBEEF;
      @(negedge clk);
      nCompared++;
      if (io_req_valid !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL bp_wait: got %b want 0", io_req_valid);
      end
      nextCycle();
      io_rsp_valid = 1'b0;
      @(negedge clk);
      exp = '{valid: 1'b1, core: 4'd0, thread_idx: 2'd2, read_value: 32'h0};
      nCompared++;
      if (ia_response !== exp) begin
         nMismatched++;
         $display("[TB] FAIL bp_rsp: got %h want %h", ia_response, exp);
      end
      clearInputs();
   endtask

   task automatic test_busy_holdoff();
      applyReset();
      req[0] = mkReq(1'b0, 32'hFFFF0020, 32'h0, 2'd0);
      @(negedge clk);
      nCompared++;
      if (ia_ready !== 4'b0001) begin
         nMismatched++;
         $display("[TB] FAIL hold_grant0: got %b want 0001", ia_ready);
      end
      nextCycle();
      req[0].valid = 1'b0;
      io_req_ready = 1'b1;
      nextCycle();
      io_req_ready = 1'b0;
      req[1] = mkReq(1'b0, 32'hFFFF0030, 32'h0, 2'd3);
      for (int k = 0; k < 3; k++) begin
         io_rsp_valid = (k == 2);
         io_read_data = 32'h000055AA;
         @(negedge clk);
         nCompared++;
         if (ia_ready !== 4'b0000) begin
            nMismatched++;
            $display("[TB] FAIL hold_busy[%0d]: got %b want 0000", k, ia_ready);
         end
         nextCycle();
      end
      io_rsp_valid = 1'b0;
      @(negedge clk);
      nCompared++;
      if ({ia_response.valid, ia_response.core, ia_ready} !== {1'b1, 4'd0, 4'b0010}) begin
         nMismatched++;
         $display("[TB] FAIL hold_regrant: got rsp %b core %0d ready %b want 1 0 0010", ia_response.valid, ia_response.core, ia_ready);
      end
      nextCycle();
      req[1].valid = 1'b0;
      @(negedge clk);
      nCompared++;
      if ({io_req_valid, io_address} !== {1'b1, 32'hFFFF0030}) begin
         nMismatched++;
         $display("[TB] FAIL hold_cmd1: got %b %h want 1 ffff0030", io_req_valid, io_address);
      end
      clearInputs();
   endtask

   task automatic test_spurious_and_reset();
      applyReset();
      io_rsp_valid = 1'b1;
      io_read_data = $urandom();
      nextCycle();
      io_rsp_valid = 1'b0;
      @(negedge clk);
      nCompared++;
      if (ia_response !== '0) begin
         nMismatched++;
         $display("[TB] FAIL spurious_rsp: got %h want 0", ia_response);
      end
      nextCycle();
      req[0] = mkReq(1'b0, 32'hFFFF0040, 32'h0, 2'd1);
      @(negedge clk);
      nCompared++;
      if (ia_ready !== 4'b0001) begin
         nMismatched++;
         $display("[TB] FAIL sr_grant: got %b want 0001", ia_ready);
      end
      nextCycle();
      req[0].valid = 1'b0;
      io_req_ready = 1'b1;
      nextCycle();
      io_req_ready = 1'b0;
      req[0] = mkReq(1'b0, 32'hFFFF0050, 32'h0, 2'd2);
      req[1] = mkReq(1'b0, 32'hFFFF0060, 32'h0, 2'd3);
      #2 reset = 1'b1;
      #1;
      nCompared++;
      if ({ia_ready, ia_response, io_req_valid, io_write_en, io_address, io_write_data} !== '0) begin
         nMismatched++;
         $display("[TB] FAIL sr_reset_outputs: got %b %h %b %b %h %h want zeros", ia_ready, ia_response, io_req_valid, io_write_en, io_address, io_write_data);
      end
      io_rsp_valid = 1'b1;
      nextCycle();
      reset = 1'b0;
      io_rsp_valid = 1'b0;
      @(negedge clk);
      nCompared++;
      if ({ia_ready, ia_response.valid} !== {4'b0001, 1'b0}) begin
         nMismatched++;
         $display("[TB] FAIL sr_after_reset: got ready %b rsp %b want 0001 0", ia_ready, ia_response.valid);
      end
      clearInputs();
   endtask

   task automatic test_random();
      bit            pend [N];
      bit            busy;
      bit            accepted;
      int            lastG;
      int            pick;
      int            txnCore;
      ioreq_packet_t txn;
      iorsp_packet_t rspExp;
      iorsp_packet_t nextRsp;
      logic [N-1:0]  expReady;
      applyReset();
      for (int i = 0; i < N; i++) pend[i] = 1'b0;
      busy     = 1'b0;
      accepted = 1'b0;
      lastG    = N - 1;
      txnCore  = 0;
      txn      = '0;
      rspExp   = '0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         @(negedge clk);
         expReady = '0;
         pick     = -1;
         if (!busy) begin
            for (int k = 1; k <= N; k++) begin
               if (pick < 0 && pend[(lastG + k) % N]) pick = (lastG + k) % N;
            end
         end
         if (pick >= 0) expReady[pick] = 1'b1;
         nCompared++;
         if (ia_ready !== expReady) begin
            nMismatched++;
            $display("[TB] FAIL rnd_ready@%0d: got %b want %b", cyc, ia_ready, expReady);
         end
         nCompared++;
         if (io_req_valid !== (busy && !accepted)) begin
            nMismatched++;
            $display("[TB] FAIL rnd_req_valid@%0d: got %b want %b", cyc, io_req_valid, busy && !accepted);
         end
         if (busy && !accepted) begin
            nCompared++;
            if ({io_write_en, io_address, io_write_data} !== {txn.is_store, txn.address, txn.value}) begin
               nMismatched++;
               $display("[TB] FAIL rnd_cmd@%0d: got %b %h %h want %b %h %h", cyc, io_write_en, io_address, io_write_data, txn.is_store, txn.address, txn.value);
            end
         end
         nCompared++;
         if (ia_response !== rspExp) begin
            nMismatched++;
            $display("[TB] FAIL rnd_rsp@%0d: got %h want %h", cyc, ia_response, rspExp);
         end
         nextRsp = '0;
         if (pick >= 0) begin
            busy       = 1'b1;
            accepted   = 1'b0;
            txn        = req[pick];
            txnCore    = pick;
            lastG      = pick;
            pend[pick] = 1'b0;
         end else if (busy && !accepted && io_req_ready) begin
            accepted = 1'b1;
         end else if (busy && accepted && io_rsp_valid) begin
            busy               = 1'b0;
            nextRsp.valid      = 1'b1;
            nextRsp.core       = core_id_t'(txnCore);
            nextRsp.thread_idx = txn.thread_idx;
            nextRsp.read_value = txn.is_store ? 32'h0 : io_read_data;
         end
         rspExp = nextRsp;
         nextCycle();
         for (int c = 0; c < N; c++) begin
            if (!pend[c]) begin
               req[c].valid = 1'b0;
               if ($urandom_range(2) == 0) begin
                  req[c] = mkReq(1'($urandom_range(1)), $urandom(), $urandom(), thread_idx_t'($urandom_range(3)));
                  pend[c] = 1'b1;
               end
            end
         end
         io_req_ready = 1'($urandom_range(1));
         io_rsp_valid = ($urandom_range(9) < 4);
         io_read_data = $urandom();
      end
      clearInputs();
   endtask

   initial begin
      test_reset();
      test_single_load();
      test_round_robin();
      test_backpressure();
      test_busy_holdoff();
      test_spurious_and_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
